// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: shares the single hps_io SD sector interface between
// floppy drives A: (d0) and B: (d1). It grants one sector transaction at a
// time in round-robin order, latches LBA and operation, steers buffer strobes
// and write data, and pulses a per-drive completion.
// Optional watchdog abort: define SD_ARB_TIMEOUT_EN.
module sd_drive_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64000000,
    parameter int unsigned TW             = 26
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [31:0] d0_lba,
    input  logic        d0_rd,
    input  logic        d0_wr,
    input  logic [7:0]  d0_buff_din,
    output logic        d0_buff_wr,
    output logic        d0_busy,
    output logic        d0_done,
    output logic        d0_err,

    input  logic [31:0] d1_lba,
    input  logic        d1_rd,
    input  logic        d1_wr,
    input  logic [7:0]  d1_buff_din,
    output logic        d1_buff_wr,
    output logic        d1_busy,
    output logic        d1_done,
    output logic        d1_err,

    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_DONE
    } state_t;

    // The watchdog counter must be able to reach TIMEOUT_CYCLES-1.
    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TW)) begin : g_bad_tw
        $error("sd_drive_arbiter: TW too small for TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic [1:0]  sd_rd_q, sd_rd_d;
    logic [1:0]  sd_wr_q, sd_wr_d;
    logic [1:0]  busy_q, busy_d;
    logic [1:0]  done_q, done_d;

    logic        req0, req1;
    logic        g;
    logic        op_rd;
    logic        timeout_hit;
    logic        can_grant;

`ifdef SD_ARB_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;

    assign timeout_hit = (state_q == S_ISSUE || state_q == S_XFER)
                         && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    // A late ack from an aborted transfer must drain before the next grant.
    assign can_grant   = ~sd_ack;
    assign d0_err      = err_q[0];
    assign d1_err      = err_q[1];
`else
    assign timeout_hit = 1'b0;
    assign can_grant   = 1'b1;
    assign d0_err      = 1'b0;
    assign d1_err      = 1'b0;
`endif

    assign req0 = d0_rd | d0_wr;
    assign req1 = d1_rd | d1_wr;

    // Next-state logic: arbitration in IDLE, handshake with hps_io afterwards.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sd_lba_d     = sd_lba_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        busy_d       = busy_q;
        done_d       = '0;
        g            = 1'b0;
        op_rd        = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = '0;
        if (state_q == S_ISSUE || state_q == S_XFER) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if ((req0 || req1) && can_grant) begin
                    g            = (req0 && req1) ? ~last_grant_q : req1;
                    op_rd        = g ? d1_rd : d0_rd;
                    grant_d      = g;
                    last_grant_d = g;
                    sd_lba_d     = g ? d1_lba : d0_lba;
                    sd_rd_d      = '0;
                    sd_wr_d      = '0;
                    sd_rd_d[g]   = op_rd;
                    sd_wr_d[g]   = ~op_rd;
                    busy_d       = '0;
                    busy_d[g]    = 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE, S_XFER: begin
                if (timeout_hit) begin
                    sd_rd_d          = '0;
                    sd_wr_d          = '0;
                    busy_d           = '0;
                    done_d[grant_q]  = 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
                    err_d[grant_q]   = 1'b1;
`endif
                    state_d          = S_DONE;
                end else if (state_q == S_ISSUE) begin
                    if (sd_ack) begin
                        sd_rd_d = '0;
                        sd_wr_d = '0;
                        state_d = S_XFER;
                    end
                end else if (!sd_ack) begin
                    busy_d          = '0;
                    done_d[grant_q] = 1'b1;
                    state_d         = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; last_grant resets to B so A wins the first tie.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            sd_lba_q     <= '0;
            sd_rd_q      <= '0;
            sd_wr_q      <= '0;
            busy_q       <= '0;
            done_q       <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sd_lba_q     <= sd_lba_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign sd_lba  = sd_lba_q;
    assign sd_rd   = sd_rd_q;
    assign sd_wr   = sd_wr_q;
    assign d0_busy = busy_q[0];
    assign d1_busy = busy_q[1];
    assign d0_done = done_q[0];
    assign d1_done = done_q[1];

    // Buffer steering toward the granted drive only; IDLE defaults to drive A data.
    always_comb begin
        d0_buff_wr  = 1'b0;
        d1_buff_wr  = 1'b0;
        sd_buff_din = d0_buff_din;
        if (state_q == S_ISSUE || state_q == S_XFER) begin
            d0_buff_wr = sd_buff_wr & ~grant_q;
            d1_buff_wr = sd_buff_wr &  grant_q;
        end
        if (state_q != S_IDLE && grant_q) begin
            sd_buff_din = d1_buff_din;
        end
    end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed self-checking bench for sd_drive_arbiter (default build, no watchdog).
module tb_sd_drive_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] d0_lba, d1_lba;
    logic        d0_rd, d0_wr, d1_rd, d1_wr;
    logic [7:0]  d0_buff_din, d1_buff_din;
    logic        d0_buff_wr, d1_buff_wr;
    logic        d0_busy, d1_busy, d0_done, d1_done, d0_err, d1_err;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned c0, c1;

    sd_drive_arbiter #(.TIMEOUT_CYCLES(100), .TW(26)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .d0_lba      (d0_lba),
        .d0_rd       (d0_rd),
        .d0_wr       (d0_wr),
        .d0_buff_din (d0_buff_din),
        .d0_buff_wr  (d0_buff_wr),
        .d0_busy     (d0_busy),
        .d0_done     (d0_done),
        .d0_err      (d0_err),
        .d1_lba      (d1_lba),
        .d1_rd       (d1_rd),
        .d1_wr       (d1_wr),
        .d1_buff_din (d1_buff_din),
        .d1_buff_wr  (d1_buff_wr),
        .d1_busy     (d1_busy),
        .d1_done     (d1_done),
        .d1_err      (d1_err),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // Ack rises for one cycle then falls; afterwards the DUT sits in DONE.
    task automatic ack_pulse;
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        d0_lba = '0; d1_lba = '0;
        d0_rd = 0; d0_wr = 0; d1_rd = 0; d1_wr = 0;
        d0_buff_din = '0; d1_buff_din = '0;
        sd_ack = 0; sd_buff_wr = 0;
        repeat (3) tick();
        check("rst_lba", sd_lba, 32'h0);
        check("rst_rdwr", {sd_rd, sd_wr}, 4'b0000);
        check("rst_flags", {d0_busy, d1_busy, d0_done, d1_done, d0_err, d1_err, d0_buff_wr, d1_buff_wr}, 8'h00);
        reset = 1'b0;
        tick();

        // Single read on drive A
        d0_lba = 32'h12; d0_rd = 1;
        tick();
        check("t1_strobe", sd_rd, 2'b01);
        check("t1_wr", sd_wr, 2'b00);
        check("t1_lba", sd_lba, 32'h12);
        check("t1_busy", {d1_busy, d0_busy}, 2'b01);
        tick(); tick();
        check("t1_hold", sd_rd, 2'b01);
        sd_ack = 1;
        tick();
        check("t1_clear", sd_rd, 2'b00);
        sd_buff_wr = 1; #1;
        check("t1_bwr", {d1_buff_wr, d0_buff_wr}, 2'b01);
        sd_buff_wr = 0;
        repeat (6) tick();
        check("t1_nodone", d0_done, 1'b0);
        check("t1_lba_xfer", sd_lba, 32'h12);
        sd_ack = 0;
        tick();
        check("t1_done", {d0_done, d0_err, d0_busy}, 3'b100);
        check("t1_d1_quiet", {d1_busy, d1_done, d1_err}, 3'b000);
        d0_rd = 0;
        tick();
        check("t1_done_pulse", d0_done, 1'b0);

        // Simultaneous requests after reset: A first, then B
        reset = 1; tick(); reset = 0; tick();
        d0_rd = 1; d0_lba = 32'hA0; d1_wr = 1; d1_lba = 32'hB1;
        tick();
        check("t2_a_first", {sd_rd, sd_wr}, 4'b0100);
        check("t2_a_lba", sd_lba, 32'hA0);
        ack_pulse();
        check("t2_a_done", {d1_done, d0_done}, 2'b01);
        d0_rd = 0;
        tick();
        check("t2_b_wait", d1_busy, 1'b0);
        tick();
        check("t2_b_strobe", {sd_rd, sd_wr}, 4'b0010);
        check("t2_b_lba", sd_lba, 32'hB1);
        check("t2_b_busy", {d1_busy, d0_busy}, 2'b10);
        ack_pulse();
        check("t2_b_done", {d1_done, d0_done}, 2'b10);
        d1_wr = 0;
        tick();
        d0_rd = 1; d1_rd = 1;
        tick();
        check("t2_rr_a", sd_rd, 2'b01);
        ack_pulse();
        d0_rd = 0; d1_rd = 0;
        tick();
        d0_rd = 1; d1_rd = 1;
        tick();
        check("t2_rr_b", sd_rd, 2'b10);
        ack_pulse();
        check("t2_rr_b_done", d1_done, 1'b1);
        d0_rd = 0; d1_rd = 0;
        tick();

        // Buffer steering: 512 strobes during a drive B read
        d1_rd = 1; d1_lba = 32'h200; d0_buff_din = 8'hA5; d1_buff_din = 8'h5A;
        tick();
        check("t3_b_strobe", sd_rd, 2'b10);
        sd_ack = 1;
        tick();
        c0 = 0; c1 = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_wr = 1; #1;
            c0 += d0_buff_wr;
            c1 += d1_buff_wr;
            tick();
            sd_buff_wr = 0;
            tick();
        end
        check("t3_d1_pulses", c1, 512);
        check("t3_d0_pulses", c0, 0);
        check("t3_din_b", sd_buff_din, 8'h5A);
        sd_ack = 0;
        tick();
        check("t3_b_done", d1_done, 1'b1);
        d1_rd = 0;
        tick();
        check("t3_din_idle", sd_buff_din, 8'hA5);

        // Drive A write: data tracks d0_buff_din
        d0_wr = 1; d0_lba = 32'h33;
        tick();
        check("t3_a_wr", {sd_rd, sd_wr}, 4'b0001);
        d0_buff_din = 8'hC3; #1;
        check("t3_din_a0", sd_buff_din, 8'hC3);
        d0_buff_din = 8'h3C; #1;
        check("t3_din_a1", sd_buff_din, 8'h3C);
        ack_pulse();
        check("t3_a_done", d0_done, 1'b1);
        d0_wr = 0;
        tick();

        // rd+wr together is a read
        d0_rd = 1; d0_wr = 1;
        tick();
        check("t4_rdwr", {sd_rd, sd_wr}, 4'b0100);
        ack_pulse();
        d0_rd = 0; d0_wr = 0;
        tick();

        // Reset during XFER, then B alone is granted while A waits
        d0_rd = 1;
        tick();
        sd_ack = 1;
        tick();
        check("t5_xfer_busy", d0_busy, 1'b1);
        reset = 1; d1_rd = 1;
        tick();
        check("t5_rst_strobe", {sd_rd, sd_wr}, 4'b0000);
        check("t5_rst_flags", {d0_busy, d0_done, d1_busy, d1_done}, 4'b0000);
        d0_rd = 0; sd_ack = 0;
        tick();
        reset = 0;
        tick();
        check("t5_b_grant", sd_rd, 2'b10);
        d0_rd = 1;
        tick();
        check("t5_a_waits", {d0_busy, sd_rd}, 3'b010);
        ack_pulse();
        check("t5_b_done", {d1_done, d0_done}, 2'b10);
        d1_rd = 0;
        tick();
        tick();
        check("t5_a_grant", sd_rd, 2'b01);
        ack_pulse();
        d0_rd = 0;
        tick();

        // No watchdog in the default build: strobe holds indefinitely
        d0_rd = 1;
        tick();
        repeat (999) tick();
        check("t6_strobe_1000", sd_rd, 2'b01);
        check("t6_no_abort", {d0_done, d0_err, d0_busy}, 3'b001);
        reset = 1; d0_rd = 0;
        tick();
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
